// File: rtl/leaf_egress_buffer.sv
// Elastic egress FIFO between the leaf converged packet stream and the BFT switch leaf port.
// Full-FIFO offers are dropped and answered with a one-cycle registered resend request.
module leaf_egress_buffer #(
   parameter int PACKET_BITS        = 97,
   parameter int DEPTH_BITS         = 3,
   parameter int ALMOST_FULL_MARGIN = 2,
   parameter int CNT_BITS           = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PACKET_BITS-1:0] stream_in,
   output logic                   resend,
   output logic [PACKET_BITS-1:0] pkt_out,
   input  logic                   pkt_ack,
   output logic [DEPTH_BITS:0]    count,
   output logic                   almost_full,
   output logic [CNT_BITS-1:0]    reject_cnt
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS + 1)'(DEPTH);
   localparam logic [DEPTH_BITS:0] AF_LEVEL   = (DEPTH_BITS + 1)'(DEPTH - ALMOST_FULL_MARGIN);

   logic [PACKET_BITS-1:0] mem [DEPTH];
   logic [DEPTH_BITS-1:0]  wr_ptr;
   logic [DEPTH_BITS-1:0]  rd_ptr;
   logic [DEPTH_BITS:0]    count_nxt;
   logic                   in_vld;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   reject;

   // All qualifiers look at pre-edge state, so a pop never frees room for a same-cycle push.
   assign in_vld = stream_in[PACKET_BITS-1];
   assign full   = (count == FULL_LEVEL);
   assign empty  = (count == '0);
   assign push   = in_vld && !full;
   assign reject = in_vld && full;
   assign pop    = pkt_ack && !empty;

   assign count_nxt = count + (DEPTH_BITS + 1)'(push) - (DEPTH_BITS + 1)'(pop);

   // Show-ahead head with no empty bypass; stale entries are masked while empty.
   assign pkt_out = empty ? '0 : mem[rd_ptr];

   // NOTE: storage has no reset; occupancy alone decides what is visible, and a
   // resettable array would cost a mux per bit for no functional gain.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= stream_in;
      end
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values,
   // which is what makes the simultaneous push/pop cases well defined.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         resend      <= 1'b0;
         almost_full <= 1'b0;
         reject_cnt  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + DEPTH_BITS'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + DEPTH_BITS'(1);
         end
         count       <= count_nxt;
         almost_full <= (count_nxt >= AF_LEVEL);
         resend      <= reject;
         if (reject && (reject_cnt != '1)) begin
            reject_cnt <= reject_cnt + CNT_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_leaf_egress_buffer.sv
// Scoreboard bench for leaf_egress_buffer: directed stimulus queues expected packets,
// an independent monitor compares every acknowledged head against that queue.
module tb_leaf_egress_buffer;

   localparam int PB = 97;
   localparam int DB = 3;
   localparam int CB = 16;

   logic          clk;
   logic          reset;
   logic [PB-1:0] stream_in;
   logic          resend;
   logic [PB-1:0] pkt_out;
   logic          pkt_ack;
   logic [DB:0]   count;
   logic          almost_full;
   logic [CB-1:0] reject_cnt;

   logic [PB-1:0] exp_q [$];
   int            m_count;
   int            n_checks;
   int            n_pass;

   leaf_egress_buffer #(
      .PACKET_BITS        (PB),
      .DEPTH_BITS         (DB),
      .ALMOST_FULL_MARGIN (2),
      .CNT_BITS           (CB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stream_in   (stream_in),
      .resend      (resend),
      .pkt_out     (pkt_out),
      .pkt_ack     (pkt_ack),
      .count       (count),
      .almost_full (almost_full),
      .reject_cnt  (reject_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PB-1:0] mk(input logic [31:0] p);
      logic [PB-1:0] v;
      v          = '0;
      v[PB-1]    = 1'b1;
      v[95:64]   = ~p;
      v[31:0]    = p;
      return v;
   endfunction

   task automatic check_pkt(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_state(input string tag, input int c, input int rs, input int af, input int rj);
      check_val({tag, "_count"}, int'(count), c);
      check_val({tag, "_resend"}, int'(resend), rs);
      check_val({tag, "_almost_full"}, int'(almost_full), af);
      check_val({tag, "_reject_cnt"}, int'(reject_cnt), rj);
   endtask

   // Called at posedge+1; holds inputs over exactly one rising edge and returns at posedge+1.
   task automatic step(input logic [PB-1:0] pkt, input logic ack);
      bit acc;
      bit pop;
      acc       = pkt[PB-1] && (m_count != (1 << DB));
      pop       = ack && (m_count != 0);
      stream_in = pkt;
      pkt_ack   = ack;
      @(posedge clk);
      #1;
      if (acc) exp_q.push_back(pkt);
      m_count   = m_count + int'(acc) - int'(pop);
      stream_in = '0;
      pkt_ack   = 1'b0;
   endtask

   // Monitor: every acked cycle, the head on pkt_out must be the oldest outstanding packet.
   always @(negedge clk) begin
      if (reset && pkt_ack) begin
         if (exp_q.size() > 0) check_pkt("pop_order", pkt_out, exp_q.pop_front());
         else check_pkt("ack_empty_out", pkt_out, '0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      m_count   = 0;
      reset     = 1'b0;
      stream_in = '0;
      pkt_ack   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_pkt("reset_pkt_out", pkt_out, '0);
      check_state("reset", 0, 0, 0, 0);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         step('0, 1'b0);
         check_pkt("idle_pkt_out", pkt_out, '0);
         check_state("idle", 0, 0, 0, 0);
      end

      // Single packet, then a junk word with the valid flag low.
      step(mk(32'hA5), 1'b0);
      check_pkt("single_head", pkt_out, mk(32'hA5));
      check_val("single_count", int'(count), 1);
      step('0, 1'b1);
      check_pkt("single_drained", pkt_out, '0);
      check_val("single_count0", int'(count), 0);
      step({1'b0, 96'hDEAD_BEEF_0123_4567_89AB_CDEF}, 1'b0);
      check_val("invalid_not_stored", int'(count), 0);
      check_pkt("invalid_pkt_out", pkt_out, '0);

      // Fill to eight; almost_full from six.
      for (int i = 0; i < 8; i++) begin
         step(mk(32'd100 + 32'(i)), 1'b0);
         check_state("fill", i + 1, 0, (i + 1 >= 6) ? 1 : 0, 0);
      end
      check_pkt("fill_head", pkt_out, mk(32'd100));

      step(mk(32'd108), 1'b0);
      check_state("reject1", 8, 1, 1, 1);
      step(mk(32'd108), 1'b1);
      check_state("reject2", 7, 1, 1, 2);
      step(mk(32'd108), 1'b0);
      check_state("accept8", 8, 0, 1, 2);

      repeat (4) step('0, 1'b1);
      check_state("drain4", 4, 0, 0, 2);
      step(mk(32'd200), 1'b1);
      check_state("pushpop4", 4, 0, 0, 2);

      // Twenty pushes with continuous ack, crossing the pointer wrap several times.
      for (int i = 0; i < 20; i++) begin
         step(mk(32'd300 + 32'(i)), 1'b1);
      end
      check_val("stream_count", int'(count), 4);
      for (int i = 0; i < 16 && m_count > 0; i++) step('0, 1'b1);
      check_val("stream_drained", int'(count), 0);
      check_val("stream_queue_empty", exp_q.size(), 0);

      for (int i = 0; i < 5; i++) begin
         step('0, 1'b1);
         check_val("ack_empty_count", int'(count), 0);
      end
      step(mk(32'h77), 1'b0);
      check_pkt("after_empty_ack_head", pkt_out, mk(32'h77));
      check_val("after_empty_ack_count", int'(count), 1);
      step('0, 1'b1);

      // Asynchronous reset with five packets stored.
      for (int i = 0; i < 5; i++) step(mk(32'd400 + 32'(i)), 1'b0);
      check_val("pre_reset_count", int'(count), 5);
      reset = 1'b0;
      #1;
      check_pkt("async_reset_pkt_out", pkt_out, '0);
      check_state("async_reset", 0, 0, 0, 0);
      exp_q.delete();
      m_count = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      step(mk(32'h55), 1'b0);
      check_pkt("post_reset_head", pkt_out, mk(32'h55));
      check_val("post_reset_count", int'(count), 1);
      step('0, 1'b1);
      check_val("post_reset_drained", int'(count), 0);
      check_val("final_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/leaf_egress_buffer.md
Name: leaf_egress_buffer

Overview:
Elastic egress stage between the leaf interface's converged packet stream and the BFT switch leaf port. It sits directly downstream of the leaf stream flow control block.
- Captures every valid packet presented on stream_in into a FIFO.
- Presents the FIFO head to the switch, which pops it with a one-cycle ack.
- When the FIFO is full it rejects the packet and raises a registered resend request, so the upstream converge controller re-presents the same packet.

Parameters:
PACKET_BITS, 97, packet width; bit PACKET_BITS-1 is the packet valid flag.
DEPTH_BITS, 3, log2 of FIFO depth (default 8 entries).
ALMOST_FULL_MARGIN, 2, almost_full asserts when free entries <= this value.
CNT_BITS, 16, width of the reject counter.

Ports:
clk  input  1  single clock for the whole block.
reset  input  1  asynchronous, active-low reset.
stream_in  input  PACKET_BITS  packet from upstream; valid when stream_in[PACKET_BITS-1]=1.
resend  output  1  registered; tells upstream to re-present the packet it offered last cycle.
pkt_out  output  PACKET_BITS  FIFO head to switch; all-zero when empty.
pkt_ack  input  1  switch consumed pkt_out this cycle.
count  output  DEPTH_BITS+1  current occupancy, 0..2^DEPTH_BITS.
almost_full  output  1  registered; count >= 2^DEPTH_BITS - ALMOST_FULL_MARGIN.
reject_cnt  output  CNT_BITS  number of rejected valid packets, saturating.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-safe release):
  - wr_ptr, rd_ptr, count, resend, almost_full and reject_cnt all clear to 0.
  - pkt_out is 0 because the FIFO is empty.
  - Memory contents are not reset.
- Definitions:
  - in_vld = stream_in[PACKET_BITS-1].
  - full = (count == 2^DEPTH_BITS).
  - empty = (count == 0).
  - All of these are evaluated on pre-edge state.
- Push: in_vld && !full → mem[wr_ptr] <= stream_in, and wr_ptr increments.
- Reject: in_vld && full → nothing is written.
  - resend <= 1 on the next edge, otherwise resend <= 0. resend is high exactly one cycle per rejected offer.
  - reject_cnt increments and saturates at 2^CNT_BITS-1.
- Pop: pkt_ack && !empty → rd_ptr increments.
  - pkt_ack while empty is ignored: no pointer or count change.
- pkt_out is show-ahead and combinational from mem[rd_ptr] gated by !empty.
  - Latency from push edge to visibility on pkt_out is 1 cycle.
  - There is no bypass when empty.
- Simultaneous push and pop:
  - Not full and not empty: both happen and count is unchanged.
  - Full: the pop happens but the push is still rejected, because full is evaluated pre-edge. count becomes 2^DEPTH_BITS-1 and resend is asserted.
  - Empty with pkt_ack: only the push happens.
- count update: count + push - pop, where push and pop are 1-bit qualified events.
- Pointers are DEPTH_BITS wide and wrap modulo 2^DEPTH_BITS with no special handling.
- almost_full is registered from the next-state count.
- Packets with in_vld=0 are never stored, whatever their other bits hold.
- Packet order is strictly preserved and no packet is duplicated.
- Reset asserted mid-operation discards all stored packets immediately. pkt_out goes to 0 asynchronously because count is cleared.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, drive stream_in=0 → pkt_out=0, count=0, resend=0, reject_cnt=0 for 10 cycles.
- Single packet: push P1 (valid, payload 0xA5) with pkt_ack=0 → pkt_out=P1 and count=1 one cycle later. Ack one cycle → count=0, pkt_out=0.
- Fill and reject (DEPTH_BITS=3):
  - Push 8 packets P0..P7 with no ack → count=8; almost_full=1 from count=6.
  - Offer P8 → resend=1 for exactly one cycle and reject_cnt=1.
  - Ack once while re-offering P8 → P8 rejected again (full pre-edge), reject_cnt=2.
  - Next cycle P8 accepted, count=8.
- Simultaneous push/pop at count=4 → count stays 4. Drain order equals push order across the pointer wrap (push 20 packets total, ack continuously) → all 20 received in order, no duplicates.
- Ack on empty: pkt_ack=1 with count=0 for 5 cycles → count stays 0 and pointers unchanged. A subsequent push is seen correctly on pkt_out.
- Reset mid-stream: assert reset=0 while count=5 → count=0 and pkt_out=0 immediately. After release, a new push shows the new packet, not stale data.
